truth_table_characterizer: RTL and testbench
============================================

Name: truth_table_characterizer

Overview:
- Sequential characterizer for 3-input, 1-output logic gate modules of the kind the compiler consumes.
- Drives all 8 input combinations onto a device-under-characterization (DUC), waits a programmable settle time and samples its output.
- Assembles the 8-bit truth-table rule code and compares it against an expected code.
- Sits between a gate netlist and the test/verification harness.

Parameters:
- SETTLE_CYCLES, 3, cycles each input vector is held before sampling; legal range 0..255.
- SYNC_STAGES, 2, flip-flop synchronizer depth on duc_out; legal range 0..3, where 0 means a direct sample.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a characterization run; honoured only in IDLE.
- abort  input  1  cancels a run in progress.
- expect_rule  input  8  expected rule code; sampled on the cycle start is accepted.
- duc_in  output  3  drives {in1,in2,in3}; in1 is the MSB.
- duc_out  input  1  DUC output; may be asynchronous to clk.
- busy  output  1  high from start acceptance until done/abort.
- done  output  1  one-cycle pulse when a run completes.
- rule  output  8  measured code; rule[i] = DUC output for duc_in == i.
- match  output  1  (rule == captured expect_rule); valid when done, held until next start.

Behaviour:
- Reset values (async, rst_n low): state IDLE, duc_in 3'b000, busy 0, done 0, rule 8'h00, match 0, index 0, settle counter 0, synchronizer flops 0.
- Synchronizer: duc_out passes through SYNC_STAGES flops, giving sync_out. SETTLE_CYCLES must be >= SYNC_STAGES; the block does not enforce this.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE; index=0, duc_in=0, counter=SETTLE_CYCLES, busy=1, expect_rule captured, rule cleared to 0.
  - start=0 -> remain in IDLE.
- SETTLE:
  - Counter decrements each cycle.
  - Counter==0 -> SAMPLE. With SETTLE_CYCLES=0, SETTLE lasts exactly 1 cycle.
- SAMPLE (1 cycle):
  - rule[index] <= sync_out.
  - If index==7 -> DONE.
  - Otherwise index+1, duc_in=index+1, counter reloaded, -> SETTLE.
- DONE (1 cycle): done=1, busy=0, match updated, duc_in returns to 0 -> IDLE.
- Latency: start accepted at cycle 0; done asserted at cycle 8*(SETTLE_CYCLES+2)+1, i.e. cycle 41 with the default.
- duc_in changes only on SETTLE entry; it is stable for SETTLE_CYCLES+2 cycles per vector.
- start while busy or in DONE: ignored, no restart.
- abort (any non-IDLE state):
  - Next state IDLE, busy=0, done stays 0, duc_in=0.
  - rule keeps its partial contents; match=0.
  - abort wins over a simultaneous SAMPLE-to-DONE transition.
- abort in IDLE: no effect. If start and abort are asserted together in IDLE, abort wins and the run is not started.
- Reset mid-run: immediate return to reset values; no done pulse.
- index is 3 bits; there is no wrap beyond 7 because DONE terminates the run.

Test Plan:
- AND3 model, defaults: pulse start with expect_rule=8'h80 -> busy for 41 cycles, done at cycle 41, rule=8'h80, match=1.
- XOR3 model, SETTLE_CYCLES=0, SYNC_STAGES=0: expect_rule=8'h96 -> done at cycle 17, rule=8'h96, match=1; duc_in steps 0..7, each held 2 cycles.
- Table model with outputs 1 only for inputs 010, 100, 101; expect_rule=8'h00 -> rule=8'h34, match=0.
- DUC output delayed by 2 cycles with SETTLE_CYCLES=1 -> stale samples produce a wrong rule; rerun with SETTLE_CYCLES=3 -> correct rule.
- abort on the cycle after the 4th SAMPLE -> busy=0 the next cycle, no done, duc_in=0, rule[3:0] holds the partial result; a new start gives a full correct run.
- start pulsed mid-run, and rst_n pulsed low mid-run -> start is ignored (no restart, latency unchanged); reset forces all outputs to reset values asynchronously.

Source files
------------

// File: rtl/truth_table_characterizer_if.sv
// Bundle of run-control, result and DUC-drive signals for truth_table_characterizer.
// master = harness side (also models the DUC output), slave = characterizer.
interface truth_table_characterizer_if;
    logic       start;
    logic       abort;
    logic [7:0] expect_rule;
    logic [2:0] duc_in;
    logic       duc_out;
    logic       busy;
    logic       done;
    logic [7:0] rule;
    logic       match;

    modport master (
        output start, abort, expect_rule, duc_out,
        input  duc_in, busy, done, rule, match
    );

    modport slave (
        input  start, abort, expect_rule, duc_out,
        output duc_in, busy, done, rule, match
    );
endinterface

// File: rtl/truth_table_characterizer.sv
// Walks a 3-input gate through all 8 input vectors, samples its (synchronized) output
// after a settle time and reports the 8-bit rule code plus a compare against an expected code.
module truth_table_characterizer #(
    parameter int SETTLE_CYCLES = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    truth_table_characterizer_if.slave  bus
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t     state_reg;
    logic [2:0] index_reg;
    logic [7:0] count_reg;
    logic [7:0] expect_reg;
    logic [7:0] rule_reg;
    logic [2:0] duc_in_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       match_reg;
    logic       sync_out;

    // duc_out may be asynchronous to clk; zero stages means the caller guarantees it is not.
    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sync_out = bus.duc_out;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= bus.duc_out;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_reg[i] <= sync_reg[i-1];
                    end
                end
            end

            assign sync_out = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            index_reg  <= 3'd0;
            count_reg  <= 8'd0;
            expect_reg <= 8'h00;
            rule_reg   <= 8'h00;
            duc_in_reg <= 3'b000;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            match_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Abort outranks every transition, including the final SAMPLE -> DONE step.
            if (state_reg != IDLE && bus.abort) begin
                state_reg  <= IDLE;
                busy_reg   <= 1'b0;
                duc_in_reg <= 3'b000;
                match_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_reg  <= SETTLE;
                            index_reg  <= 3'd0;
                            duc_in_reg <= 3'b000;
                            count_reg  <= SETTLE_LOAD;
                            busy_reg   <= 1'b1;
                            expect_reg <= bus.expect_rule;
                            rule_reg   <= 8'h00;
                        end
                    end
                    SETTLE: begin
                        if (count_reg == 8'd0) begin
                            state_reg <= SAMPLE;
                        end else begin
                            count_reg <= count_reg - 8'd1;
                        end
                    end
                    SAMPLE: begin
                        rule_reg[index_reg] <= sync_out;
                        if (index_reg == 3'd7) begin
                            state_reg <= DONE;
                        end else begin
                            index_reg  <= index_reg + 3'd1;
                            duc_in_reg <= index_reg + 3'd1;
                            count_reg  <= SETTLE_LOAD;
                            state_reg  <= SETTLE;
                        end
                    end
                    DONE: begin
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        match_reg  <= (rule_reg == expect_reg);
                        duc_in_reg <= 3'b000;
                        state_reg  <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.duc_in = duc_in_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.rule   = rule_reg;
    assign bus.match  = match_reg;

endmodule

// File: tb/tb_truth_table_characterizer.sv
// Directed bench: three characterizer instances (default, zero-settle/direct-sample,
// short-settle) each driven by a truth-table gate model with an optional 2-cycle output delay.
module tb_truth_table_characterizer;

    logic clk;
    logic rst_n;

    logic [7:0] tt_v    [3];
    logic       dly_v   [3];
    logic       start_v [3];
    logic       abort_v [3];
    logic [7:0] exp_v   [3];

    logic [2:0] busy_w;
    logic [2:0] done_w;
    logic [2:0] match_w;
    logic [7:0] rule_w   [3];
    logic [2:0] duc_in_w [3];

    logic       busy_h [128];
    logic [2:0] duc_h  [128];

    int n_assert = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            truth_table_characterizer_if bus ();
            logic f;
            logic d1 = 1'b0;
            logic d2 = 1'b0;

            assign f = tt_v[gi][bus.duc_in];
            always @(posedge clk) begin
                d1 <= f;
                d2 <= d1;
            end

            assign bus.start       = start_v[gi];
            assign bus.abort       = abort_v[gi];
            assign bus.expect_rule = exp_v[gi];
            assign bus.duc_out     = dly_v[gi] ? d2 : f;
            assign busy_w[gi]      = bus.busy;
            assign done_w[gi]      = bus.done;
            assign match_w[gi]     = bus.match;
            assign rule_w[gi]      = bus.rule;
            assign duc_in_w[gi]    = bus.duc_in;

            truth_table_characterizer #(
                .SETTLE_CYCLES ((gi == 0) ? 3 : ((gi == 1) ? 0 : 1)),
                .SYNC_STAGES   ((gi == 1) ? 0 : 2)
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the cycle right after the edge that accepts start.
    task automatic run(input int d, input logic [7:0] e, input int inj_start, input int inj_abort,
                       input int bound, output int lat, output int busy_n, output bit seen);
        exp_v[d]   = e;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (lat <= bound) begin
            busy_h[lat] = busy_w[d];
            duc_h[lat]  = duc_in_w[d];
            if (busy_w[d]) busy_n++;
            if (done_w[d]) begin
                seen = 1'b1;
                break;
            end
            start_v[d] = (lat == inj_start);
            abort_v[d] = (lat == inj_abort);
            tick();
            lat++;
        end
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
    endtask

    initial begin
        int  lat;
        int  bn;
        bit  seen;
        bit  any_done;

        for (int i = 0; i < 3; i++) begin
            tt_v[i]    = 8'h00;
            dly_v[i]   = 1'b0;
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            exp_v[i]   = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("reset_busy",   32'(busy_w[0]),   32'h0);
        chk("reset_done",   32'(done_w[0]),   32'h0);
        chk("reset_rule",   32'(rule_w[0]),   32'h0);
        chk("reset_match",  32'(match_w[0]),  32'h0);
        chk("reset_duc_in", 32'(duc_in_w[0]), 32'h0);

        // AND3 with default timing
        tt_v[0] = 8'h80;
        run(0, 8'h80, -1, -1, 100, lat, bn, seen);
        chk("and3_done_seen", 32'(seen), 32'h1);
        chk("and3_latency", 32'(lat), 32'd41);
        chk("and3_busy_cycles", 32'(bn), 32'd41);
        chk("and3_busy_c1", 32'(busy_h[1]), 32'h1);
        chk("and3_rule", 32'(rule_w[0]), 32'h80);
        chk("and3_match", 32'(match_w[0]), 32'h1);
        tick();
        chk("and3_done_pulse", 32'(done_w[0]), 32'h0);

        // XOR3, no settle, direct sample
        tt_v[1] = 8'h96;
        run(1, 8'h96, -1, -1, 100, lat, bn, seen);
        chk("xor3_done_seen", 32'(seen), 32'h1);
        chk("xor3_latency", 32'(lat), 32'd17);
        chk("xor3_rule", 32'(rule_w[1]), 32'h96);
        chk("xor3_match", 32'(match_w[1]), 32'h1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("xor3_duc_in_c%0d", k), 32'(duc_h[k]), 32'(k / 2));
        end
        chk("xor3_duc_in_c16", 32'(duc_h[16]), 32'd7);
        chk("xor3_duc_in_done", 32'(duc_h[17]), 32'd0);

        // Sparse table (010, 100, 101) with deliberately wrong expectation
        tt_v[0] = 8'h34;
        run(0, 8'h00, -1, -1, 100, lat, bn, seen);
        chk("tbl_done_seen", 32'(seen), 32'h1);
        chk("tbl_rule", 32'(rule_w[0]), 32'h34);
        chk("tbl_match", 32'(match_w[0]), 32'h0);

        // MAJ3 behind a 2-cycle delay: settle 1 samples the previous vector
        tt_v[2]  = 8'hE8;
        dly_v[2] = 1'b1;
        repeat (4) tick();
        run(2, 8'hE8, -1, -1, 100, lat, bn, seen);
        chk("dly_s1_done_seen", 32'(seen), 32'h1);
        chk("dly_s1_latency", 32'(lat), 32'd25);
        chk("dly_s1_rule", 32'(rule_w[2]), 32'hD0);
        chk("dly_s1_match", 32'(match_w[2]), 32'h0);

        tt_v[0]  = 8'hE8;
        dly_v[0] = 1'b1;
        repeat (4) tick();
        run(0, 8'hE8, -1, -1, 100, lat, bn, seen);
        chk("dly_s3_done_seen", 32'(seen), 32'h1);
        chk("dly_s3_rule", 32'(rule_w[0]), 32'hE8);
        chk("dly_s3_match", 32'(match_w[0]), 32'h1);
        dly_v[0] = 1'b0;
        repeat (4) tick();

        // Abort the cycle after the 4th SAMPLE (cycle 19), then a clean rerun
        run(0, 8'hE8, -1, 20, 60, lat, bn, seen);
        chk("abort_no_done", 32'(seen), 32'h0);
        chk("abort_busy_before", 32'(busy_h[20]), 32'h1);
        chk("abort_busy_after", 32'(busy_h[21]), 32'h0);
        chk("abort_duc_in", 32'(duc_h[21]), 32'h0);
        chk("abort_rule_partial", 32'(rule_w[0]), 32'h08);
        chk("abort_match", 32'(match_w[0]), 32'h0);
        run(0, 8'hE8, -1, -1, 100, lat, bn, seen);
        chk("post_abort_done_seen", 32'(seen), 32'h1);
        chk("post_abort_latency", 32'(lat), 32'd41);
        chk("post_abort_rule", 32'(rule_w[0]), 32'hE8);
        chk("post_abort_match", 32'(match_w[0]), 32'h1);

        // Start re-pulsed mid-run must not restart the sequence
        tt_v[0] = 8'hFE;
        run(0, 8'hFE, 10, -1, 100, lat, bn, seen);
        chk("midstart_done_seen", 32'(seen), 32'h1);
        chk("midstart_latency", 32'(lat), 32'd41);
        chk("midstart_rule", 32'(rule_w[0]), 32'hFE);
        chk("midstart_match", 32'(match_w[0]), 32'h1);

        // Asynchronous reset in the middle of a run
        tt_v[0]    = 8'hFF;
        exp_v[0]   = 8'hFF;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (10) tick();
        chk("rstmid_rule_before", 32'(rule_w[0]), 32'h03);
        chk("rstmid_busy_before", 32'(busy_w[0]), 32'h1);
        chk("rstmid_match_before", 32'(match_w[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy_w[0]), 32'h0);
        chk("rstmid_rule", 32'(rule_w[0]), 32'h0);
        chk("rstmid_match", 32'(match_w[0]), 32'h0);
        chk("rstmid_duc_in", 32'(duc_in_w[0]), 32'h0);
        chk("rstmid_done", 32'(done_w[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        any_done = 1'b0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (done_w[0] || busy_w[0]) any_done = 1'b1;
        end
        chk("rstmid_no_done_after", 32'(any_done), 32'h0);
        run(0, 8'hFF, -1, -1, 100, lat, bn, seen);
        chk("post_rst_done_seen", 32'(seen), 32'h1);
        chk("post_rst_latency", 32'(lat), 32'd41);
        chk("post_rst_rule", 32'(rule_w[0]), 32'hFF);
        chk("post_rst_match", 32'(match_w[0]), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
